// File: rtl/line_window_buffer_pkg.sv
// Shared ConvUnit definitions: default geometry and tap-slice indexing for the
// packed column bus.
package line_window_buffer_pkg;

   localparam int DATA_WIDTH_DEF     = 8;
   localparam int MAX_LINE_WIDTH_DEF = 128;
   localparam int ADDR_WIDTH_DEF     = $clog2(MAX_LINE_WIDTH_DEF);

   // Slice k of a column occupies [(k+1)*dw-1 : k*dw].
   function automatic int tap_lsb(input int k, input int dw);
      return k * dw;
   endfunction

endpackage

// File: rtl/line_window_buffer_line_ram.sv
// One stored image row: circular memory with asynchronous read and synchronous
// write, so the same-cycle read returns the value being overwritten.
module line_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 128,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   assign o_rd_data = r_mem[i_addr];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wr_data;
   end

endmodule

// File: rtl/line_window_buffer.sv
// Multi-line raster buffer: each accepted pixel yields a column of the current
// pixel plus the NUM_LINES pixels directly above it.
module line_window_buffer
   import line_window_buffer_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int MAX_LINE_WIDTH = MAX_LINE_WIDTH_DEF,
   parameter int NUM_LINES      = 2,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
   input  logic                              Clk,
   input  logic                              Rst,
   input  logic                              clear,
   input  logic [ADDR_WIDTH:0]               line_width,
   input  logic                              valid_in,
   input  logic [DATA_WIDTH-1:0]             data_in,
   output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] tap_out,
   output logic                              valid_out,
   output logic [ADDR_WIDTH-1:0]             col_out,
   output logic                              eol_out
);

   localparam int                FW   = $clog2(NUM_LINES + 1);
   localparam logic [ADDR_WIDTH:0] MAXW = (ADDR_WIDTH + 1)'(MAX_LINE_WIDTH);

   logic [ADDR_WIDTH:0]                    r_cfg_width;
   logic [ADDR_WIDTH-1:0]                  r_ptr;
   logic [FW-1:0]                          r_fill;
   logic [NUM_LINES:0][DATA_WIDTH-1:0]     r_tap;
   logic                                   r_valid;
   logic                                   r_eol;
   logic [ADDR_WIDTH-1:0]                  r_col;

   logic [NUM_LINES-1:0][DATA_WIDTH-1:0]   w_old;
   logic [NUM_LINES-1:0][DATA_WIDTH-1:0]   w_wdata;
   logic                                   w_accept;
   logic                                   w_last;
   logic                                   w_full;

   assign w_accept = valid_in & ~clear;
   assign w_last   = ({1'b0, r_ptr} == (r_cfg_width - (ADDR_WIDTH + 1)'(1)));
   assign w_full   = (r_fill == FW'(NUM_LINES));

   // Line k+1 inherits what line k held at this column, shifting rows down.
   genvar g;
   generate
      for (g = 0; g < NUM_LINES; g++) begin : g_line
         if (g == 0) begin : g_head
            assign w_wdata[g] = data_in;
         end else begin : g_chain
            assign w_wdata[g] = w_old[g-1];
         end
         line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (MAX_LINE_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_line (
            .i_clk     (Clk),
            .i_we      (w_accept),
            .i_addr    (r_ptr),
            .i_wr_data (w_wdata[g]),
            .o_rd_data (w_old[g])
         );
      end
      for (g = 0; g <= NUM_LINES; g++) begin : g_tap
         localparam int LSB = tap_lsb(g, DATA_WIDTH);
         assign tap_out[LSB +: DATA_WIDTH] = r_tap[g];
      end
   endgenerate

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_cfg_width <= MAXW;
         r_ptr       <= '0;
         r_fill      <= '0;
         r_tap       <= '0;
         r_valid     <= 1'b0;
         r_eol       <= 1'b0;
         r_col       <= '0;
      end else if (clear) begin
         r_cfg_width <= ((line_width == '0) || (line_width > MAXW)) ? MAXW : line_width;
         r_ptr       <= '0;
         r_fill      <= '0;
         r_valid     <= 1'b0;
         r_eol       <= 1'b0;
      end else if (valid_in) begin
         r_tap[0] <= data_in;
         for (int k = 0; k < NUM_LINES; k++) r_tap[k+1] <= w_old[k];
         r_col   <= r_ptr;
         r_eol   <= w_last;
         r_valid <= w_full;
         if (w_last) begin
            r_ptr <= '0;
            if (!w_full) r_fill <= r_fill + FW'(1);
         end else begin
            r_ptr <= r_ptr + ADDR_WIDTH'(1);
         end
      end else begin
         // Stall: column and taps hold, only the per-sample flags drop.
         r_valid <= 1'b0;
         r_eol   <= 1'b0;
      end
   end

   assign valid_out = r_valid;
   assign eol_out   = r_eol;
   assign col_out   = r_col;

endmodule
